// File: rtl/alu_pkg.sv
// Shared opcode map and FSM encoding for the pipelined EX-stage ALU.
package alu_pkg;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_ZERO = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_t;
endpackage

// File: rtl/alu_if.sv
// Operand/result handshake bundle between the pipeline and the ALU.
interface alu_if #(parameter int WIDTH = 32);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              a;
  logic [WIDTH-1:0]              b;
  logic [alu_pkg::ALU_OP_W-1:0]  aluc;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              alu_out;
  logic                          zero;
  logic                          overflow;
  logic                          illegal;

  modport master (
    output in_valid, a, b, aluc, out_ready,
    input  in_ready, out_valid, alu_out, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, a, b, aluc, out_ready,
    output in_ready, out_valid, alu_out, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one partial product per clock, WIDTH steps after start.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0] mplier_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0] acc_next;

  // The final step's sum is handed out combinationally so the caller registers it on the last edge.
  always_comb begin
    acc_next = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);
    done     = busy && (cnt == CNT_W'(WIDTH-1));
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // Step stage: operands shift, accumulator absorbs one partial product
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= a;
      mplier_p1 <= b;
      acc_p1    <= '0;
    end else if (busy) begin
      acc_p1    <= acc_next;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: single-cycle ops, iterative MUL, valid/ready on both sides.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;
  logic signed [WIDTH-1:0] res;
  logic [SHAMT_W-1:0]      shamt;
  logic                    ovf;
  logic                    ill;
  logic                    is_mul;
  logic                    accept;
  logic                    in_ready;
  alu_state_t              state;
  alu_state_t              state_nxt;
  logic                    mul_done;
  logic [WIDTH-1:0]        mul_prod;

  logic signed [WIDTH-1:0] res_p1;
  logic                    zero_p1;
  logic                    ovf_p1;
  logic                    ill_p1;
  logic                    vld_p1;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  always_comb begin
    a_s    = $signed(bus.a);
    b_s    = $signed(bus.b);
    shamt  = bus.b[SHAMT_W-1:0];
    sum    = a_s + b_s;
    diff   = a_s - b_s;
    is_mul = MUL_EN && (bus.aluc == ALU_MUL);
    accept = bus.in_valid && in_ready;
  end

  always_comb begin
    res = '0;
    ovf = 1'b0;
    ill = 1'b0;
    case (bus.aluc)
      ALU_AND:  res = a_s & b_s;
      ALU_OR:   res = a_s | b_s;
      ALU_ADD: begin
        res = sum;
        ovf = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_XOR:  res = a_s ^ b_s;
      ALU_LUI:  res = b_s << (WIDTH/2);
      ALU_SLL:  res = a_s << shamt;
      ALU_SUB: begin
        res = diff;
        ovf = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], diff[WIDTH-1]);
      end
      ALU_ZERO: res = '0;
      ALU_SRL:  res = $signed(bus.a >> shamt);
      ALU_SRA:  res = a_s >>> shamt;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      // Result of an accepted MUL arrives from the multiplier, never from this path
      ALU_MUL:  ill = !MUL_EN;
      default:  ill = 1'b1;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_BUSY;
      ST_BUSY: if (mul_done)         state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst_n && (state == ST_IDLE) && (!vld_p1 || bus.out_ready);
  end

  // Output stage: result and flags registered together, held under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (mul_done) begin
      vld_p1  <= 1'b1;
      res_p1  <= $signed(mul_prod);
      zero_p1 <= (mul_prod == '0);
      ovf_p1  <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (accept && !is_mul) begin
      vld_p1  <= 1'b1;
      res_p1  <= res;
      zero_p1 <= (res == '0);
      ovf_p1  <= ovf;
      ill_p1  <= ill;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = vld_p1;
    bus.alu_out   = res_p1;
    bus.zero      = zero_p1;
    bus.overflow  = ovf_p1;
    bus.illegal   = ill_p1;
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors, decoupled monitor, WIDTH=16 side instance.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(32)) bus ();
  alu_if #(.WIDTH(16)) bus16 ();

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_pipe #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic [2:0]  flg;   // {zero, overflow, illegal}
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got %h, expected none", bus.alu_out);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_res"}, bus.alu_out, e.res);
        chk({e.nm, "_flags"}, {29'b0, bus.zero, bus.overflow, bus.illegal}, {29'b0, e.flg});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send(input string nm, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic [2:0] f,
                      input bit push);
    int n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.aluc = op;
    #1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    if (push) begin
      e.nm = nm;
      e.res = r;
      e.flg = f;
      sbq.push_back(e);
    end
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int c0;
    logic bad;
    logic seen;
    logic [31:0] held;
    logic [2:0]  held_f;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.aluc = '0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.aluc = '0; bus16.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_alu_out", bus.alu_out, 32'd0);
    chk("rst_flags", {29'b0, bus.zero, bus.overflow, bus.illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply must abort it
    send("mul_abort", ALU_MUL, 32'd7, 32'd6, 32'd42, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      bad |= bus.out_valid | bus.in_ready | (bus.alu_out != 0);
    end
    chk("midmul_rst_outputs", {31'b0, bad}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= bus.out_valid;
    end
    chk("no_stale_mul", {31'b0, seen}, 32'd0);

    send("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b010, 1'b1);
    bus.in_valid = 1'b0;
    chk("add_latency1", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    send("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'd0, 3'b100, 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream, one accept per cycle
    send("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 3'b000, 1'b1);
    c0 = cyc;
    send("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 3'b000, 1'b1);
    send("srl_shamt_mask", ALU_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 3'b000, 1'b1);
    send("lui", ALU_LUI, 32'd0, 32'h1234, 32'h1234_0000, 3'b000, 1'b1);
    send("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 3'b000, 1'b1);
    send("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b100, 1'b1);
    send("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 3'b000, 1'b1);
    send("or", ALU_OR, 32'h0F00_00F0, 32'h00F0_000F, 32'h0FF0_00FF, 3'b000, 1'b1);
    send("xor", ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 3'b000, 1'b1);
    send("sll", ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, 3'b000, 1'b1);
    send("zero_op", ALU_ZERO, 32'd5, 32'd6, 32'd0, 3'b100, 1'b1);
    send("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b010, 1'b1);
    send("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b100, 1'b1);
    send("ill_1111", 4'b1111, 32'd5, 32'd5, 32'd0, 3'b101, 1'b1);
    send("ill_1101", 4'b1101, 32'd9, 32'd3, 32'd0, 3'b101, 1'b1);
    chk("throughput_cycles", cyc - c0, 32'd14);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    send("mul_7x6", ALU_MUL, 32'd7, 32'd6, 32'd42, 3'b000, 1'b1);
    bus.in_valid = 1'b0;
    bad = bus.in_ready;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.out_valid) bad |= bus.in_ready;
    end
    chk("mul_latency", n, 32'd32);
    chk("mul_busy_in_ready", {31'b0, bad}, 32'd0);
    @(posedge clk); #1;
    send("mul_wrap", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 3'b000, 1'b1);
    bus.in_valid = 1'b0;
    wait_valid("mul_wrap");
    @(posedge clk); #1;

    // Backpressure: result and flags must freeze until out_ready returns
    bus.out_ready = 1'b0;
    send("bp_add", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b010, 1'b1);
    bus.in_valid = 1'b0;
    held = bus.alu_out;
    held_f = {bus.zero, bus.overflow, bus.illegal};
    bad = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      bad |= (bus.alu_out !== held) || ({bus.zero, bus.overflow, bus.illegal} !== held_f)
             || !bus.out_valid;
      seen |= bus.in_ready;
    end
    chk("bp_stable", {31'b0, bad}, 32'd0);
    chk("bp_in_ready", {31'b0, seen}, 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_retire", {31'b0, bus.out_valid}, 32'd0);

    // Narrow build, MUL disabled
    bus16.a = 16'h7FFF; bus16.b = 16'h0001; bus16.aluc = ALU_ADD; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    chk("w16_add_valid", {31'b0, bus16.out_valid}, 32'd1);
    chk("w16_add_res", {16'h0, bus16.alu_out}, 32'h0000_8000);
    chk("w16_add_ovf", {31'b0, bus16.overflow}, 32'd1);
    bus16.a = 16'd3; bus16.b = 16'd3; bus16.aluc = ALU_MUL; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    chk("w16_mul_off_res", {16'h0, bus16.alu_out}, 32'd0);
    chk("w16_mul_off_flags", {29'b0, bus16.zero, bus16.overflow, bus16.illegal}, 32'd5);

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
